// File: rtl/aib_hrdrst_pkg.sv
// Shared state type and counter-width helper for the AIB hard-reset
// oscillator-transfer sequencer (optional build macro: AIB_HRDRST_OSC_TIMEOUT_EN).
package aib_hrdrst_pkg;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_CLK   = 3'd1,
        ST_WAIT_SL_EN = 3'd2,
        ST_READY      = 3'd3,
        ST_RETRY      = 3'd4,
        ST_ERROR      = 3'd5
    } hrdrst_osc_state_t;

    // Bits needed to hold num_values distinct values, never less than one.
    function automatic int cnt_width(input int num_values);
        return (num_values <= 2) ? 1 : $clog2(num_values);
    endfunction

endpackage

// File: rtl/aib_hrdrst_osc_ch.sv
// One AIB channel: wait-clock counter, slave-enable synchroniser and handshake FSM.
// Timeout/retry logic is present only when AIB_HRDRST_OSC_TIMEOUT_EN is defined.
module aib_hrdrst_osc_ch
    import aib_hrdrst_pkg::*;
#(
    parameter int WAIT_CYC    = 15,
    parameter int SYNC_STAGES = 2
`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1023,
    parameter int MAX_RETRY   = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ch_en,
    input  logic sl_en,
    output logic ms_en,
    output logic ready,
    output logic err
);

    localparam int CW = cnt_width(WAIT_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC);

    hrdrst_osc_state_t      state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic                   ms_reg, ms_next;
    logic                   sl_sync;

`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam int RW = cnt_width(MAX_RETRY + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [TW-1:0] to_reg, to_next;
    logic [RW-1:0] retry_reg, retry_next;
`endif

    assign sl_sync = sync_reg[SYNC_STAGES-1];

    // The chain only runs while we request, so a slave enable left high from an
    // earlier attempt still costs the full synchroniser latency after ms_en rises.
    assign sync_next = (state_reg == ST_WAIT_SL_EN) ?
                       {sync_reg[SYNC_STAGES-2:0], sl_en} : '0;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
        retry_next = retry_reg;
        to_next    = (state_reg == ST_WAIT_SL_EN) ? to_reg + TW'(1) : '0;
`endif
        case (state_reg)
            ST_RESET: begin
                if (ch_en) state_next = ST_WAIT_CLK;
            end
            ST_WAIT_CLK: begin
                if (cnt_reg == '0) state_next = ST_WAIT_SL_EN;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            ST_WAIT_SL_EN: begin
                // WAIT_SL_EN lasts TIMEOUT_CYC cycles; a slave enable on the last one still wins.
                if (sl_sync) begin
                    state_next = ST_READY;
                end
`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
                else if (to_reg == TO_LAST) begin
                    if (retry_reg == RETRY_MAX) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_RETRY;
                        retry_next = retry_reg + RW'(1);
                    end
                end
`endif
            end
            ST_READY: state_next = ST_READY;
`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
            ST_RETRY: state_next = ST_WAIT_CLK;
            ST_ERROR: state_next = ST_ERROR;
`endif
            default:  state_next = ST_RESET;
        endcase

        if (state_next != ST_WAIT_CLK) cnt_next = CNT_LOAD;

        if (!ch_en) begin
            state_next = ST_RESET;
            cnt_next   = CNT_LOAD;
`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
            retry_next = '0;
`endif
        end

        ms_next = (state_next == ST_WAIT_SL_EN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RESET;
            cnt_reg   <= CNT_LOAD;
            sync_reg  <= '0;
            ms_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sync_reg  <= sync_next;
            ms_reg    <= ms_next;
        end
    end

`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_reg    <= '0;
            retry_reg <= '0;
        end else begin
            to_reg    <= to_next;
            retry_reg <= retry_next;
        end
    end

    assign err = (state_reg == ST_ERROR);
`else
    assign err = 1'b0;
`endif

    assign ms_en = ms_reg;
    assign ready = (state_reg == ST_READY);

endmodule

// File: rtl/aib_hrdrst_osc_seq.sv
// Multi-channel AIB hard-reset oscillator-transfer handshake on the aux clock.
// Define AIB_HRDRST_OSC_TIMEOUT_EN to add per-channel timeout, retry and error.
module aib_hrdrst_osc_seq
    import aib_hrdrst_pkg::*;
#(
    parameter int NUM_CH      = 1,
    parameter int WAIT_CYC    = 15,
    parameter int SYNC_STAGES = 2
`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1023,
    parameter int MAX_RETRY   = 3
`endif
) (
    input  logic              i_aux_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic [NUM_CH-1:0] c_sl_osc_transfer_en,
    output logic [NUM_CH-1:0] c_ms_osc_transfer_en,
    output logic [NUM_CH-1:0] o_ch_ready,
    output logic [NUM_CH-1:0] o_err,
    output logic              o_done
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            aib_hrdrst_osc_ch #(
                .WAIT_CYC    (WAIT_CYC),
                .SYNC_STAGES (SYNC_STAGES)
`ifdef AIB_HRDRST_OSC_TIMEOUT_EN
                ,
                .TIMEOUT_CYC (TIMEOUT_CYC),
                .MAX_RETRY   (MAX_RETRY)
`endif
            ) u_ch (
                .clk   (i_aux_clk),
                .rst_n (i_rst_n),
                .ch_en (i_ch_en[gi]),
                .sl_en (c_sl_osc_transfer_en[gi]),
                .ms_en (c_ms_osc_transfer_en[gi]),
                .ready (o_ch_ready[gi]),
                .err   (o_err[gi])
            );
        end
    endgenerate

    // An empty mask is never "done": nothing was brought up.
    assign o_done = (|i_ch_en) & (&(~i_ch_en | o_ch_ready));

endmodule
